// File: rtl/regfile_write_arbiter.sv
// Round-robin writeback arbiter for the single register-block write port.
// Also runs a zero-fill of r1..r(NUM_REGS-1) after reset or on clearReq.
module regfile_write_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  input  logic              clear_req,
  output logic              busy,
  output logic [ADDR_W-1:0] writeReg,
  output logic              writeEn,
  output logic [DATA_W-1:0] writeData
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

  state_t            state;
  state_t            stateNext;
  logic [ADDR_W-1:0] cnt;
  logic              lastGrantB;
  logic              runOpen;
  logic              grantA;
  logic              grantB;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state <= CLEAR;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      CLEAR: if (cnt == LAST_REG) stateNext = RUN;
      RUN:   if (clear_req)       stateNext = CLEAR;
    endcase
  end

  // Grants are purely combinational; a clear request blocks both this cycle.
  always_comb begin
    runOpen = (state == RUN) && !clear_req;
    grantA  = runOpen && a_valid && (!b_valid || lastGrantB);
    grantB  = runOpen && b_valid && (!a_valid || !lastGrantB);
    a_ready = grantA;
    b_ready = grantB;
    busy    = (state == CLEAR);
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cnt <= FIRST_REG;
    end else if (state == CLEAR) begin
      cnt <= (cnt == LAST_REG) ? FIRST_REG : cnt + FIRST_REG;
    end
  end

  // Reset points at B so the first tie goes to A.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      lastGrantB <= 1'b1;
    end else if (grantA) begin
      lastGrantB <= 1'b0;
    end else if (grantB) begin
      lastGrantB <= 1'b1;
    end
  end

  // Write-port register stage; r0 writes are accepted but never enabled.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      writeEn   <= 1'b0;
      writeReg  <= '0;
      writeData <= '0;
    end else if (state == CLEAR) begin
      writeEn   <= 1'b1;
      writeReg  <= cnt;
      writeData <= '0;
    end else if (grantA) begin
      writeEn   <= (a_addr != '0);
      writeReg  <= a_addr;
      writeData <= a_data;
    end else if (grantB) begin
      writeEn   <= (b_addr != '0);
      writeReg  <= b_addr;
      writeData <= b_data;
    end else begin
      writeEn   <= 1'b0;
    end
  end

endmodule
